// File: rtl/divider.sv
// Sequential unsigned restoring divider: 16-bit dividend / 8-bit divisor,
// one quotient bit per cycle, fixed 16-cycle latency with valid/ready handshake.
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_a,
    input  logic [7:0]  in_b,
    input  logic        in_vld,
    output logic [15:0] quo,
    output logic [7:0]  rem,
    output logic        dz,
    output logic        res_rdy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] work;
    logic [7:0]  dvs;
    logic [7:0]  prem;
    logic [3:0]  cnt;

    logic [8:0]  trial;
    logic        take;
    logic [8:0]  diff;
    logic [7:0]  prem_nxt;
    logic [15:0] work_nxt;
    logic        last_iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_vld) state_nxt = BUSY;
            BUSY:    if (last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign res_rdy   = (state == IDLE);
    assign last_iter = (cnt == 4'd15);

    // The stored remainder is always below the divisor, so 8 bits suffice;
    // the 9-bit trial value carries the bit shifted in from the dividend.
    always_comb begin
        trial    = {prem, work[15]};
        take     = (trial >= {1'b0, dvs});
        diff     = trial - {1'b0, dvs};
        prem_nxt = take ? diff[7:0] : trial[7:0];
        work_nxt = {work[14:0], take};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work <= 16'h0000;
            dvs  <= 8'h00;
            prem <= 8'h00;
            cnt  <= 4'd0;
            quo  <= 16'h0000;
            rem  <= 8'h00;
            dz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_vld) begin
                        work <= in_a;
                        dvs  <= in_b;
                        prem <= 8'h00;
                        cnt  <= 4'd0;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    prem <= prem_nxt;
                    cnt  <= cnt + 4'd1;
                    // Divide by zero still runs the full 16 cycles, then overrides the result.
                    if (last_iter) begin
                        if (dvs == 8'h00) begin
                            quo <= 16'hFFFF;
                            rem <= 8'h00;
                            dz  <= 1'b1;
                        end else begin
                            quo <= work_nxt;
                            rem <= prem_nxt;
                            dz  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
